// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one async-FIFO write port among NREQ requesters.
// Optional full-stall counter enabled by defining WR_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                    wclk_i,
  input  logic                    wrst_n_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DSIZE-1:0]   wdata_i,
  output logic [NREQ-1:0]         ack_o,
  input  logic                    fifo_full_i,
  input  logic                    fifo_almost_full_i,
  output logic                    wen_o,
  output logic [DSIZE-1:0]        wdata_o,
  output logic [NREQ-1:0]         grant_o,
  output logic [15:0]             stall_cnt_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX) + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_gidx;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;

  logic            w_req_g;
  logic            w_wen;
  logic            w_exit;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW:0]     w_t;
  logic [DSIZE-1:0] w_slice;

  // r_grant is zero outside BURST, so w_req_g is only meaningful while a grant is held
  assign w_req_g = |(req_i & r_grant);
  assign w_wen   = (r_state == S_BURST) & w_req_g & ~fifo_full_i;
  assign w_exit  = (r_state == S_BURST) &
                   (~w_req_g | (w_wen & ((r_cnt == CW'(BURST_MAX-1)) | fifo_almost_full_i)));

  always_comb begin
    w_slice = '0;
    for (int k = 0; k < NREQ; k++)
      if (r_grant[k]) w_slice = w_slice | wdata_i[k*DSIZE +: DSIZE];
  end

  assign wen_o   = w_wen;
  assign wdata_o = w_wen ? w_slice : '0;
  assign ack_o   = w_wen ? r_grant : '0;
  assign grant_o = r_grant;

  // Search upward from last+1 with wrap; first set request wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_t     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_t = {1'b0, r_last} + (IW+1)'(i);
      if (w_t >= (IW+1)'(NREQ)) w_t = w_t - (IW+1)'(NREQ);
      if (!w_found && req_i[w_t[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_t[IW-1:0];
      end
    end
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NREQ-1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_BURST;
            r_grant <= NREQ'(1) << w_pick;
            r_gidx  <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_BURST: begin
          if (w_exit) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= r_gidx;
          end else if (w_wen) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef WR_ARB_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i)
      r_stall <= '0;
    else if ((r_state == S_BURST) && w_req_g && fifo_full_i && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  assign stall_cnt_o = r_stall;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
